// File: rtl/lcd_text_writer_pkg.sv
// Shared types and constants for the HD44780 character-stream front end.
package lcd_text_writer_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_SEND,
    S_ADDR
  } writer_states;

  localparam logic [7:0] LCD_CMD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;
  localparam logic [6:0] LCD_ROW1_BASE     = 7'h40;
  localparam logic [7:0] CH_NL             = 8'h0A;
  localparam logic [7:0] CH_CR             = 8'h0D;
  localparam logic [7:0] CH_FF             = 8'h0C;

  // Set-DDRAM-address instruction for a cursor position.
  function automatic logic [7:0] ddram_cmd(input logic row, input logic [6:0] col);
    logic [6:0] addr;
    addr = row ? (LCD_ROW1_BASE + col) : col;
    return LCD_CMD_SET_DDRAM | {1'b0, addr};
  endfunction

endpackage

// File: rtl/lcd_char_fifo.sv
// Small synchronous FIFO with first-word-fall-through read data.
module lcd_char_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (PtrW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/lcd_text_writer.sv
// Converts an ASCII byte stream into HD44780 (RS, data) commands while tracking
// the 16x2 cursor, so upstream logic never deals with DDRAM addresses.
module lcd_text_writer
  import lcd_text_writer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned COLS       = 16
) (
  input  logic                     i_board_clk,
  input  logic                     i_rst,
  input  logic                     i_char_valid,
  input  logic [7:0]               i_char,
  output logic                     o_char_ready,
  output logic                     o_cmd_valid,
  output logic                     o_cmd_rs,
  output logic [7:0]               o_cmd_data,
  input  logic                     i_cmd_ready,
  output logic                     o_row,
  output logic [$clog2(COLS)-1:0]  o_col,
  output logic                     o_busy
);

  localparam int unsigned ColW = $clog2(COLS);
  localparam logic [ColW-1:0] LastCol = ColW'(COLS - 1);

  writer_states              state_q;
  logic [7:0]                byte_q;
  logic                      wrap_pending_q;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_push;
  logic                      fifo_pop;
  logic [7:0]                fifo_rdata;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  assign o_char_ready = !fifo_full && !i_rst;
  assign fifo_push    = i_char_valid && o_char_ready;
  assign fifo_pop     = (state_q == S_IDLE) && !fifo_empty;
  assign o_busy       = (fifo_count != '0) || (state_q != S_IDLE);

  lcd_char_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk_i   (i_board_clk),
    .rst_i   (i_rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (i_char),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge i_board_clk) begin
    if (i_rst) begin
      state_q        <= S_IDLE;
      byte_q         <= 8'h00;
      wrap_pending_q <= 1'b0;
      o_cmd_valid    <= 1'b0;
      o_cmd_rs       <= 1'b0;
      o_cmd_data     <= 8'h00;
      o_row          <= 1'b0;
      o_col          <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fifo_pop) begin
            byte_q  <= fifo_rdata;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          o_cmd_valid <= 1'b1;
          state_q     <= S_SEND;
          case (byte_q)
            CH_FF: begin
              o_cmd_rs   <= 1'b0;
              o_cmd_data <= LCD_CMD_CLEAR;
              o_row      <= 1'b0;
              o_col      <= '0;
            end
            CH_NL: begin
              o_cmd_rs   <= 1'b0;
              o_cmd_data <= ddram_cmd(!o_row, 7'd0);
              o_row      <= !o_row;
              o_col      <= '0;
            end
            CH_CR: begin
              o_cmd_rs   <= 1'b0;
              o_cmd_data <= ddram_cmd(o_row, 7'd0);
              o_col      <= '0;
            end
            default: begin
              o_cmd_rs   <= 1'b1;
              o_cmd_data <= byte_q;
              if (o_col == LastCol) begin
                o_col          <= '0;
                o_row          <= !o_row;
                wrap_pending_q <= 1'b1;
              end else begin
                o_col <= o_col + 1'b1;
              end
            end
          endcase
        end
        S_SEND: begin
          if (i_cmd_ready) begin
            if (wrap_pending_q) begin
              // Cursor already holds the wrapped position; valid stays high.
              o_cmd_rs   <= 1'b0;
              o_cmd_data <= ddram_cmd(o_row, 7'(o_col));
              state_q    <= S_ADDR;
            end else begin
              o_cmd_valid <= 1'b0;
              state_q     <= S_IDLE;
            end
          end
        end
        S_ADDR: begin
          if (i_cmd_ready) begin
            o_cmd_valid    <= 1'b0;
            wrap_pending_q <= 1'b0;
            state_q        <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_text_writer.sv
// Directed and randomised checks of lcd_text_writer against a cursor/command model.
module tb_lcd_text_writer;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_char_valid;
  logic [7:0] i_char;
  logic       o_char_ready;
  logic       o_cmd_valid;
  logic       o_cmd_rs;
  logic [7:0] o_cmd_data;
  logic       i_cmd_ready;
  logic       o_row;
  logic [3:0] o_col;
  logic       o_busy;

  int tests = 0;
  int fails = 0;

  logic [8:0] sb [$];
  logic       m_row;
  logic [3:0] m_col;
  logic       rand_stall = 1'b0;

  logic       have_prev = 1'b0;
  logic       prev_valid;
  logic       prev_hs;
  logic       prev_rs;
  logic [7:0] prev_data;

  always #10 clk = ~clk;

  lcd_text_writer #(
    .FIFO_DEPTH(8),
    .COLS(16)
  ) dut (
    .i_board_clk  (clk),
    .i_rst        (i_rst),
    .i_char_valid (i_char_valid),
    .i_char       (i_char),
    .o_char_ready (o_char_ready),
    .o_cmd_valid  (o_cmd_valid),
    .o_cmd_rs     (o_cmd_rs),
    .o_cmd_data   (o_cmd_data),
    .i_cmd_ready  (i_cmd_ready),
    .o_row        (o_row),
    .o_col        (o_col),
    .o_busy       (o_busy)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] addr_instr(input logic row, input logic [3:0] col);
    return row ? (8'hC0 + {4'h0, col}) : (8'h80 + {4'h0, col});
  endfunction

  // Reference model: expected commands for one byte, plus cursor update.
  function automatic void model_byte(input logic [7:0] b);
    case (b)
      8'h0C: begin m_row = 1'b0; m_col = 4'd0; sb.push_back({1'b0, 8'h01}); end
      8'h0A: begin m_row = !m_row; m_col = 4'd0; sb.push_back({1'b0, addr_instr(m_row, m_col)}); end
      8'h0D: begin m_col = 4'd0; sb.push_back({1'b0, addr_instr(m_row, m_col)}); end
      default: begin
        sb.push_back({1'b1, b});
        if (m_col == 4'd15) begin
          m_col = 4'd0;
          m_row = !m_row;
          sb.push_back({1'b0, addr_instr(m_row, m_col)});
        end else begin
          m_col = m_col + 4'd1;
        end
      end
    endcase
  endfunction

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (rand_stall) i_cmd_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push(input logic [7:0] b);
    int n = 0;
    i_char_valid = 1'b1;
    i_char       = b;
    while (!o_char_ready && n < 5000) begin
      step();
      n++;
    end
    if (n >= 5000) check("push_timeout", 16'(o_char_ready), 16'h1);
    model_byte(b);
    step();
    i_char_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((o_busy || sb.size() != 0) && n < 20000) begin
      step();
      n++;
    end
    check({tag, "_sb_empty"}, 16'(sb.size()), 16'h0);
    check({tag, "_busy"}, 16'(o_busy), 16'h0);
    check({tag, "_row"}, 16'(o_row), 16'(m_row));
    check({tag, "_col"}, 16'(o_col), 16'(m_col));
  endtask

  // Monitor: sampled mid-cycle, so values match what the next rising edge sees.
  always @(negedge clk) begin
    logic [8:0] exp;
    if (i_rst) begin
      have_prev = 1'b0;
    end else begin
      if (have_prev && prev_valid && !prev_hs) begin
        check("hold_valid", 16'(o_cmd_valid), 16'h1);
        check("hold_cmd", {7'h0, o_cmd_rs, o_cmd_data}, {7'h0, prev_rs, prev_data});
      end
      if (o_cmd_valid && i_cmd_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_cmd", 16'(o_cmd_valid), 16'h0);
        end else begin
          exp = sb.pop_front();
          check("cmd", {7'h0, o_cmd_rs, o_cmd_data}, {7'h0, exp});
        end
      end
      have_prev = 1'b1;
      prev_valid = o_cmd_valid;
      prev_hs    = o_cmd_valid && i_cmd_ready;
      prev_rs    = o_cmd_rs;
      prev_data  = o_cmd_data;
    end
  end

  initial begin
    i_rst        = 1'b1;
    i_char_valid = 1'b0;
    i_char       = 8'h00;
    i_cmd_ready  = 1'b1;
    m_row        = 1'b0;
    m_col        = 4'd0;

    // Reset state
    step();
    step();
    check("rst_char_ready", 16'(o_char_ready), 16'h0);
    check("rst_valid", 16'(o_cmd_valid), 16'h0);
    check("rst_cmd", {7'h0, o_cmd_rs, o_cmd_data}, 16'h0);
    check("rst_cursor", {11'h0, o_row, o_col}, 16'h0);
    check("rst_busy", 16'(o_busy), 16'h0);
    i_rst = 1'b0;
    #1;
    check("post_rst_char_ready", 16'(o_char_ready), 16'h1);

    // Single character latency: written at edge k, valid after edge k+2
    push(8'h41);
    check("lat_k", 16'(o_cmd_valid), 16'h0);
    step();
    check("lat_k1", 16'(o_cmd_valid), 16'h0);
    step();
    check("lat_k2", 16'(o_cmd_valid), 16'h1);
    check("lat_k2_cmd", {7'h0, o_cmd_rs, o_cmd_data}, 16'h0141);
    check("lat_k2_cursor", {11'h0, o_row, o_col}, 16'h0001);
    wait_idle("single");

    // Line wrap: start from (0,0)
    push(8'h0C);
    wait_idle("ff0");
    for (int i = 0; i < 16; i++) push(8'h30);
    wait_idle("wrap1");
    check("wrap1_pos", {11'h0, o_row, o_col}, 16'h0010);
    for (int i = 0; i < 16; i++) push(8'h30);
    wait_idle("wrap2");
    check("wrap2_pos", {11'h0, o_row, o_col}, 16'h0000);

    // Control characters
    push(8'h48);
    push(8'h0A);
    push(8'h49);
    wait_idle("nl");
    check("nl_pos", {11'h0, o_row, o_col}, 16'h0011);
    push(8'h0D);
    wait_idle("cr");
    push(8'h0C);
    wait_idle("ff");
    check("ff_pos", {11'h0, o_row, o_col}, 16'h0000);

    // Backpressure: FIFO fills, nothing lost
    i_cmd_ready = 1'b0;
    for (int i = 0; i < 9; i++) push(8'h61 + 8'(i));
    step();
    check("bp_full_ready", 16'(o_char_ready), 16'h0);
    check("bp_valid", 16'(o_cmd_valid), 16'h1);
    check("bp_head", {7'h0, o_cmd_rs, o_cmd_data}, 16'h0161);
    i_cmd_ready = 1'b1;
    wait_idle("bp");

    // Reset while a command is pending and bytes are queued
    i_cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'h77 + 8'(i));
    check("mid_pending", 16'(o_cmd_valid), 16'h1);
    i_rst = 1'b1;
    step();
    check("mid_valid", 16'(o_cmd_valid), 16'h0);
    check("mid_busy", 16'(o_busy), 16'h0);
    check("mid_cursor", {11'h0, o_row, o_col}, 16'h0);
    sb.delete();
    m_row = 1'b0;
    m_col = 4'd0;
    i_rst = 1'b0;
    i_cmd_ready = 1'b1;
    repeat (6) step();
    check("mid_no_stale", 16'(o_cmd_valid), 16'h0);
    check("mid_idle", 16'(o_busy), 16'h0);

    // Random bytes with random ready stalls
    rand_stall = 1'b1;
    for (int i = 0; i < 100; i++) begin
      int unsigned r;
      r = $urandom_range(0, 19);
      if (r == 0)      push(8'h0A);
      else if (r == 1) push(8'h0D);
      else if (r == 2) push(8'h0C);
      else             push(8'h20 + 8'($urandom_range(0, 94)));
    end
    wait_idle("random");
    rand_stall = 1'b0;
    i_cmd_ready = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
